// File: rtl/start_scheduler_if.sv
// rtl/start_scheduler_if.sv - request/engine handshake bundle for start_scheduler
interface start_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int SEL_W = 2
);
   logic [N_REQ-1:0] req;
   logic             engine_done;
   logic             engine_start;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic [N_REQ-1:0] ack;
   logic             timeout_err;

   modport master (
      input  req, engine_done,
      output engine_start, sel, busy, ack, timeout_err
   );

   modport slave (
      output req, engine_done,
      input  engine_start, sel, busy, ack, timeout_err
   );
endinterface

// File: rtl/start_scheduler.sv
// rtl/start_scheduler.sv - round-robin sharing of one single-shot engine
// Every output is a flop loaded from next-state, so async reset clears them at once.
module start_scheduler #(
   parameter int N_REQ     = 4,
   parameter int START_LEN = 2,
   parameter int TIMEOUT   = 255,
   parameter int SEL_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input logic               clk,
   input logic               reset,
   start_scheduler_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

   localparam logic [3:0]       START_LAST = 4'(START_LEN - 1);
   localparam logic [7:0]       WAIT_LAST  = 8'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [3:0]       start_cnt_q, start_cnt_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             done_lat_q, done_lat_d;
   logic             abort_q, abort_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             tmo_q, tmo_d;
   logic             found;
   int               idx;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      start_cnt_d = start_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      done_lat_d  = done_lat_q;
      abort_d     = abort_q;
      found       = 1'b0;
      idx         = 0;

      case (state_q)
         S_IDLE: begin
            // first requester at or above the pointer, wrapping modulo N_REQ
            for (int i = 0; i < N_REQ; i++) begin
               idx = int'(ptr_q) + i;
               if (idx >= N_REQ) idx = idx - N_REQ;
               if (!found && bus.req[idx]) begin
                  found = 1'b1;
                  sel_d = SEL_W'(idx);
               end
            end
            if (found) begin
               state_d     = S_START;
               start_cnt_d = 4'd0;
            end
         end
         S_START: begin
            if (bus.engine_done) done_lat_d = 1'b1;
            if (start_cnt_q == START_LAST) begin
               state_d    = S_WAIT;
               wait_cnt_d = 8'd0;
            end else begin
               start_cnt_d = start_cnt_q + 4'd1;
            end
         end
         S_WAIT: begin
            if (bus.engine_done || done_lat_q) begin
               state_d = S_ACK;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_ACK;
               abort_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_ACK: begin
            state_d     = S_IDLE;
            ptr_d       = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            done_lat_d  = 1'b0;
            abort_d     = 1'b0;
            start_cnt_d = 4'd0;
            wait_cnt_d  = 8'd0;
         end
         default: state_d = S_IDLE;
      endcase

      start_d = (state_d == S_START);
      busy_d  = (state_d != S_IDLE);
      ack_d   = (state_d == S_ACK) ? (ONE_HOT0 << sel_d) : '0;
      tmo_d   = (state_d == S_ACK) && abort_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         start_cnt_q <= 4'd0;
         wait_cnt_q  <= 8'd0;
         done_lat_q  <= 1'b0;
         abort_q     <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         ack_q       <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         start_cnt_q <= start_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         done_lat_q  <= done_lat_d;
         abort_q     <= abort_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         tmo_q       <= tmo_d;
      end
   end

   assign bus.engine_start = start_q;
   assign bus.sel          = sel_q;
   assign bus.busy         = busy_q;
   assign bus.ack          = ack_q;
   assign bus.timeout_err  = tmo_q;
endmodule

// File: tb/tb_start_scheduler.sv
// tb/tb_start_scheduler.sv - directed self-checking bench for start_scheduler
module tb_start_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   start_scheduler_if #(.N_REQ(4), .SEL_W(2)) bus ();

   start_scheduler #(.N_REQ(4), .START_LEN(2), .TIMEOUT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      bus.req = 4'b0000;
      bus.engine_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // bounded wait for engine_start to reach lvl; n = negedges taken
   task automatic wait_es(input logic lvl, input string nm, output int n);
      n = 0;
      while (bus.engine_start !== lvl && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (bus.engine_start !== lvl) begin
         failures++;
         $display("FAIL %s: engine_start=%b after %0d cycles, required %b", nm, bus.engine_start, n, lvl);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.req = 4'b1111;
      bus.engine_done = 1'b0;
      tick();
      tick();
      checks += 5;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      if (bus.engine_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b want 0", bus.engine_start); end
      if (bus.sel !== 2'd0) begin failures++; $display("FAIL rst_sel: got %0d want 0", bus.sel); end
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
      if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_tmo: got %b want 0", bus.timeout_err); end
      bus.req = 4'b0000;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single;
      do_reset();
      bus.req = 4'b0100;
      tick();
      checks += 3;
      if (bus.engine_start !== 1'b1) begin failures++; $display("FAIL single_start0: got %b want 1", bus.engine_start); end
      if (bus.sel !== 2'd2) begin failures++; $display("FAIL single_sel: got %0d want 2", bus.sel); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      tick();
      checks++;
      if (bus.engine_start !== 1'b1) begin failures++; $display("FAIL single_start1: got %b want 1", bus.engine_start); end
      tick();
      checks += 2;
      if (bus.engine_start !== 1'b0) begin failures++; $display("FAIL single_start2: got %b want 0", bus.engine_start); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_wait_busy: got %b want 1", bus.busy); end
      tick();
      tick();
      bus.engine_done = 1'b1;
      tick();
      bus.engine_done = 1'b0;
      checks += 2;
      if (bus.ack !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b want 0100", bus.ack); end
      if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL single_tmo: got %b want 0", bus.timeout_err); end
      bus.req = 4'b0000;
      tick();
      checks += 2;
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL single_ack_len: got %b want 0000", bus.ack); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", bus.busy); end
   endtask

   task automatic test_fairness;
      int n;
      logic [3:0] exp_ack;
      do_reset();
      bus.req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_es(1'b1, "fair_start", n);
         checks += 2;
         if (n != ((t == 0) ? 1 : 2)) begin failures++; $display("FAIL fair_gap%0d: got %0d cycles want %0d", t, n, (t == 0) ? 1 : 2); end
         if (bus.sel !== 2'(t % 4)) begin failures++; $display("FAIL fair_sel%0d: got %0d want %0d", t, bus.sel, t % 4); end
         wait_es(1'b0, "fair_stop", n);
         bus.engine_done = 1'b1;
         tick();
         bus.engine_done = 1'b0;
         exp_ack = 4'b0001 << (t % 4);
         checks += 2;
         if (bus.ack !== exp_ack) begin failures++; $display("FAIL fair_ack%0d: got %b want %b", t, bus.ack, exp_ack); end
         if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL fair_tmo%0d: got %b want 0", t, bus.timeout_err); end
      end
      bus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_timeout;
      int n;
      int cnt;
      do_reset();
      bus.req = 4'b0001;
      wait_es(1'b1, "tmo_start", n);
      cnt = 0;
      while (bus.ack === 4'b0000 && cnt < 400) begin
         tick();
         cnt++;
      end
      checks += 3;
      if (cnt != 257) begin failures++; $display("FAIL tmo_latency: got %0d cycles want 257", cnt); end
      if (bus.ack !== 4'b0001) begin failures++; $display("FAIL tmo_ack: got %b want 0001", bus.ack); end
      if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b want 1", bus.timeout_err); end
      bus.req = 4'b0000;
      tick();
      checks += 2;
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL tmo_ack_len: got %b want 0000", bus.ack); end
      if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_flag_len: got %b want 0", bus.timeout_err); end
   endtask

   task automatic test_early_done;
      do_reset();
      bus.req = 4'b0010;
      tick();
      tick();
      bus.engine_done = 1'b1;
      tick();
      bus.engine_done = 1'b0;
      checks += 3;
      if (bus.engine_start !== 1'b0) begin failures++; $display("FAIL early_start: got %b want 0", bus.engine_start); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL early_wait: got %b want 1", bus.busy); end
      if (bus.ack !== 4'b0000) begin failures++; $display("FAIL early_noack: got %b want 0000", bus.ack); end
      tick();
      checks += 2;
      if (bus.ack !== 4'b0010) begin failures++; $display("FAIL early_ack: got %b want 0010", bus.ack); end
      if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL early_tmo: got %b want 0", bus.timeout_err); end
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_in_wait;
      int n;
      do_reset();
      bus.req = 4'b0001;
      wait_es(1'b1, "riw_pre_start", n);
      wait_es(1'b0, "riw_pre_stop", n);
      bus.engine_done = 1'b1;
      tick();
      bus.engine_done = 1'b0;
      bus.req = 4'b0000;
      tick();
      bus.req = 4'b0010;
      wait_es(1'b1, "riw_start", n);
      checks++;
      if (bus.sel !== 2'd1) begin failures++; $display("FAIL riw_sel1: got %0d want 1", bus.sel); end
      tick();
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.engine_start !== 1'b0) begin failures++; $display("FAIL riw_in_wait: busy=%b start=%b want 1/0", bus.busy, bus.engine_start); end
      #2 reset = 1'b1;
      #1;
      checks += 3;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL riw_busy: got %b want 0", bus.busy); end
      if (bus.sel !== 2'd0) begin failures++; $display("FAIL riw_sel_clr: got %0d want 0", bus.sel); end
      if (bus.ack !== 4'b0000 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL riw_ack: ack=%b tmo=%b want 0000/0", bus.ack, bus.timeout_err); end
      tick();
      reset = 1'b0;
      bus.req = 4'b0011;
      tick();
      checks += 2;
      if (bus.engine_start !== 1'b1) begin failures++; $display("FAIL riw_restart: got %b want 1", bus.engine_start); end
      if (bus.sel !== 2'd0) begin failures++; $display("FAIL riw_ptr: got %0d want 0", bus.sel); end
      wait_es(1'b0, "riw_stop", n);
      bus.engine_done = 1'b1;
      tick();
      bus.engine_done = 1'b0;
      checks++;
      if (bus.ack !== 4'b0001) begin failures++; $display("FAIL riw_ack0: got %b want 0001", bus.ack); end
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_dropped_req;
      int n;
      do_reset();
      bus.req = 4'b1000;
      tick();
      bus.req = 4'b0000;
      checks++;
      if (bus.engine_start !== 1'b1 || bus.sel !== 2'd3) begin failures++; $display("FAIL drop_grant: start=%b sel=%0d want 1/3", bus.engine_start, bus.sel); end
      wait_es(1'b0, "drop_stop", n);
      tick();
      bus.engine_done = 1'b1;
      tick();
      bus.engine_done = 1'b0;
      checks += 2;
      if (bus.ack !== 4'b1000) begin failures++; $display("FAIL drop_ack: got %b want 1000", bus.ack); end
      if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL drop_tmo: got %b want 0", bus.timeout_err); end
      tick();
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.engine_start !== 1'b0) begin failures++; $display("FAIL drop_idle: busy=%b start=%b want 0/0", bus.busy, bus.engine_start); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.req = 4'b0000;
      bus.engine_done = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_early_done();
      test_reset_in_wait();
      test_dropped_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/start_scheduler.md
# start_scheduler

Round-robin scheduler that shares one single-shot processing engine among `N_REQ` requesters. Each request produces a fixed-width start pulse to the engine, then waits for the engine's completion or a timeout. It then returns a one-cycle acknowledge to the granted requester. It sits between the per-channel trigger logic and the shared engine, and replaces ad-hoc per-channel start-pulse stretching.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `START_LEN`, 2: width of `engine_start` pulse in clock cycles (1..15).
- `TIMEOUT`, 255: maximum cycles spent in WAIT before abort (1..255).
- `SEL_W`, derived: `clog2(N_REQ)`, minimum 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  level request per requester; held until `ack` or dropped.
- `engine_done`  in  1  engine completion, single-cycle or level.
- `engine_start`  out  1  start strobe to engine, high for `START_LEN` cycles.
- `sel`  out  SEL_W  index of granted requester; steers engine operand mux.
- `busy`  out  1  high in every state except IDLE.
- `ack`  out  N_REQ  one-hot, one-cycle completion pulse to granted requester.
- `timeout_err`  out  1  one-cycle pulse coincident with `ack` when transaction aborted.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: state IDLE; round-robin pointer = 0; `sel`=0; `engine_start`, `busy`, `ack`, `timeout_err`, counters, done-latch all 0.
- All outputs registered; values are a function of state and registered `sel` only.
- FSM states:
  - IDLE: if `req` ≠ 0, grant the first set bit searching upward from the pointer with wrap (pointer, pointer+1, …, N_REQ-1, 0, …). Load `sel`, go START. Otherwise stay.
  - START: `engine_start`=1. A 4-bit counter runs 0..START_LEN-1. After `START_LEN` cycles go to WAIT.
  - WAIT: the 8-bit wait counter increments each cycle from 0. If `engine_done` is high or the done-latch is set, go ACK. Else, if the counter equals `TIMEOUT`-1, go ACK with the abort flag set.
  - ACK: `ack[sel]`=1 for exactly one cycle; `timeout_err`=abort flag. Pointer ← (`sel`+1) mod N_REQ. Clear the done-latch, abort flag and counters. Go IDLE.
- `engine_done` arriving during START sets the done-latch. WAIT then exits to ACK on its first cycle.
- `engine_done` in IDLE or ACK is ignored.
- Dropping `req[sel]` after the grant does not cancel the transaction; `ack` still pulses.
- Requests from other channels arriving mid-transaction wait; they are evaluated only in IDLE.
- Reset mid-transaction returns to the reset state immediately, without waiting for a clock edge. `engine_start` drops asynchronously and no `ack` is issued.
- Pointer arithmetic wraps modulo `N_REQ`. This also holds for non-power-of-two `N_REQ`; `sel` never exceeds N_REQ-1.

## Timing
- Request latency: `req` sampled high at edge E0 → `busy`, `engine_start` and `sel` valid from E0 through E0+START_LEN.
- `engine_start` is high for exactly `START_LEN` consecutive cycles per transaction and is never back-to-back across transactions.
- `engine_done` sampled high at edge Ed in WAIT → `ack` high for the cycle after Ed → IDLE on the following edge.
- Without done: `ack` and `timeout_err` go high exactly `START_LEN`+`TIMEOUT` cycles after `engine_start` first rises.
- Minimum transaction length is `START_LEN`+2 cycles (START, one WAIT, ACK); the earliest next `engine_start` follows one IDLE cycle.
- `sel` is stable from grant until leaving ACK.

## Test plan
- Single request, defaults: `req`=0100, `engine_done` pulsed 3 cycles after `engine_start` falls.
  - Expected: `engine_start` high 2 cycles, `sel`=2, `ack`=0100 for one cycle, `timeout_err`=0, `busy` low the next cycle.
- Fairness: `req`=1111 held, `engine_done` pulsed 1 cycle into every WAIT.
  - Expected: grant order `sel`=0,1,2,3,0; each `ack` one-hot and matching.
- Timeout: `req`=0001, `engine_done` never asserted.
  - Expected: `ack`=0001 and `timeout_err`=1 together, 257 cycles after `engine_start` rises, both for one cycle.
- Early done: `engine_done` pulsed during the second START cycle.
  - Expected: one WAIT cycle, then `ack`; no timeout.
- Reset in WAIT with `req`=0010: `reset` asserted between edges.
  - Expected: all outputs 0 before the next edge. After release with `req`=0011, `sel`=0 (pointer reset).
- Dropped request: `req`=1000 for one cycle only.
  - Expected: full transaction completes, `ack`=1000 pulses, then IDLE with `busy`=0.
